// File: rtl/mac_slice_serial_if.sv
// Plane/result handshake bundle for the bit-serial MAC slice.
// The master side streams bit-planes and collects results; the slave side is the slice.
interface mac_slice_serial_if #(
  parameter int N  = 256,
  parameter int WB = 4,
  parameter int IB = 8
);
  localparam int ACCW = WB + $clog2(N) + IB;

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_bits;
  logic [N*WB-1:0] weight_array;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] acc_out;
  logic            busy;

  modport master (
    output in_valid, in_bits, weight_array, out_ready,
    input  in_ready, out_valid, acc_out, busy
  );

  modport slave (
    input  in_valid, in_bits, weight_array, out_ready,
    output in_ready, out_valid, acc_out, busy
  );
endinterface

// File: rtl/mac_slice_serial.sv
// Bit-serial multiply-accumulate slice: MSB-first activation planes gate per-lane weights,
// lanes are reduced and shift-accumulated into one dot product. MAC_SLICE_SIGNED_EN selects two's complement.
module mac_slice_serial #(
  parameter int N  = 256,
  parameter int WB = 4,
  parameter int IB = 8
) (
  input logic              clk,
  input logic              rst,
  mac_slice_serial_if.slave bus
);
  localparam int ACCW = WB + $clog2(N) + IB;
  localparam int CW   = $clog2(IB + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [ACCW-1:0] acc_r, acc_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [N*WB-1:0] wreg_r, wreg_nxt_s;
  logic [N*WB-1:0] w_sel_s;
  logic [ACCW-1:0] psum_s;
  logic [ACCW-1:0] first_term_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  function automatic logic [ACCW-1:0] lane_ext(input logic [WB-1:0] w);
`ifdef MAC_SLICE_SIGNED_EN
    return {{(ACCW-WB){w[WB-1]}}, w};
`else
    return {{(ACCW-WB){1'b0}}, w};
`endif
  endfunction

  // Lane weights come straight from the bus on the first plane, from the latch afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      w_sel_s = bus.weight_array;
    end else begin
      w_sel_s = wreg_r;
    end
  end

  // Gated-weight reduction across all lanes for the current plane.
  always_comb begin
    psum_s = {ACCW{1'b0}};
    for (int i = 0; i < N; i++) begin
      psum_s = psum_s + (bus.in_bits[i] ? lane_ext(w_sel_s[WB*i +: WB]) : {ACCW{1'b0}});
    end
  end

  // In signed mode the MSB plane carries negative weight.
  always_comb begin
`ifdef MAC_SLICE_SIGNED_EN
    first_term_s = {ACCW{1'b0}} - psum_s;
`else
    first_term_s = psum_s;
`endif
  end

  // Next-state and datapath update for the frame FSM.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    wreg_nxt_s  = wreg_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          acc_nxt_s   = first_term_s;
          wreg_nxt_s  = bus.weight_array;
          cnt_nxt_s   = CW'(1);
          state_nxt_s = (IB == 1) ? DONE : ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_nxt_s = (acc_r << 1) + psum_s;
          cnt_nxt_s = cnt_r + CW'(1);
          if (cnt_r == CW'(IB - 1)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        acc_nxt_s   = {ACCW{1'b0}};
        cnt_nxt_s   = {CW{1'b0}};
        wreg_nxt_s  = {(N*WB){1'b0}};
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACCW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      wreg_r      <= {(N*WB){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      wreg_r      <= wreg_nxt_s;
      in_ready_r  <= (state_nxt_s != DONE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mac_slice_serial.sv
// Scoreboard bench for mac_slice_serial: expected results are queued per frame and
// popped when the slice presents its result.
module tb_mac_slice_serial;
  localparam int N    = 256;
  localparam int WB   = 4;
  localparam int IB   = 8;
  localparam int ACCW = WB + $clog2(N) + IB;

  typedef logic [N-1:0] frame_t [IB];

`ifdef MAC_SLICE_SIGNED_EN
  localparam logic [ACCW-1:0] E_ALL = ACCW'(256);
  localparam logic [ACCW-1:0] E_A3  = ACCW'(-465);
  localparam logic [ACCW-1:0] E_FE  = ACCW'(6);
`else
  localparam logic [ACCW-1:0] E_ALL = ACCW'(979200);
  localparam logic [ACCW-1:0] E_A3  = ACCW'(815);
  localparam logic [ACCW-1:0] E_FE  = ACCW'(3302);
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_slice_serial_if #(.N(N), .WB(WB), .IB(IB)) bus ();

  mac_slice_serial #(.N(N), .WB(WB), .IB(IB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [ACCW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [N*WB-1:0] rand_w();
    logic [N*WB-1:0] r;
    for (int k = 0; k < N*WB/32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic frame_t lane0_frame(input logic [IB-1:0] act);
    frame_t f;
    for (int p = 0; p < IB; p++) begin
      f[p]    = '0;
      f[p][0] = act[IB-1-p];
    end
    return f;
  endfunction

  // Reference dot product: gather each lane's activation from its plane bits, multiply, sum.
  function automatic logic [ACCW-1:0] model(input logic [N*WB-1:0] w, input frame_t pl);
    longint acc = 0;
    for (int i = 0; i < N; i++) begin
      longint a = 0;
      longint wi;
      for (int p = 0; p < IB; p++) a = (a << 1) | longint'(pl[p][i]);
      wi = longint'(w[WB*i +: WB]);
`ifdef MAC_SLICE_SIGNED_EN
      if (a >= (64'sd1 <<< (IB-1))) a -= (64'sd1 <<< IB);
      if (wi >= (64'sd1 <<< (WB-1))) wi -= (64'sd1 <<< WB);
`endif
      acc += a * wi;
    end
    return acc[ACCW-1:0];
  endfunction

  task automatic send_frame(input logic [N*WB-1:0] w, input frame_t pl, input logic [IB-1:0] gap,
                            input bit scramble_w, input int n_planes, input logic [ACCW-1:0] exp);
    if (n_planes == IB) exp_q.push_back(exp);
    for (int p = 0; p < n_planes; p++) begin
      @(negedge clk);
      check_eq("in_ready_plane", 64'(bus.in_ready), 64'd1);
      if (p == IB-1) check_eq("out_valid_early", 64'(bus.out_valid), 64'd0);
      bus.in_valid     = 1'b1;
      bus.in_bits      = pl[p];
      bus.weight_array = (p == 0 || !scramble_w) ? w : rand_w();
      if (gap[p]) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bits  = ~pl[p];
        check_eq("busy_stall", 64'(bus.busy), 64'd1);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
  endtask

  task automatic collect(input int hold);
    int k = 0;
    logic [ACCW-1:0] exp;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("out_valid_wait", 64'(k), 64'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check_eq("acc_out", 64'(bus.acc_out), 64'(exp));
    check_eq("in_ready_done", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check_eq("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_acc_out", 64'(bus.acc_out), 64'(exp));
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*WB-1:0] w;
    frame_t f;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_bits = '0;
    bus.weight_array = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_acc_out", 64'(bus.acc_out), 64'd0);
    rst = 1'b0;

    // All lanes max weight, all planes ones, back-to-back.
    w = '1;
    for (int p = 0; p < IB; p++) f[p] = '1;
    send_frame(w, f, '0, 1'b0, IB, E_ALL);
    collect(0);

    // Single lane, activation 0xA3, then with stalls, backpressure and weight scrambling.
    w = '0;
    w[WB-1:0] = 4'd5;
    f = lane0_frame(8'hA3);
    send_frame(w, f, '0, 1'b0, IB, E_A3);
    collect(0);
    send_frame(w, f, 8'b0001_0010, 1'b0, IB, E_A3);
    collect(5);
    send_frame(w, f, '0, 1'b1, IB, E_A3);
    collect(0);

    // Reset after three planes discards the frame.
    send_frame(w, f, '0, 1'b0, 3, '0);
    check_eq("busy_mid_frame", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("abort_acc_out", 64'(bus.acc_out), 64'd0);
    send_frame(w, f, '0, 1'b0, IB, E_A3);
    collect(0);

    // Negative weight / negative activation in signed mode.
    w = '0;
    w[WB-1:0] = 4'b1101;
    f = lane0_frame(8'hFE);
    send_frame(w, f, '0, 1'b0, IB, E_FE);
    collect(1);

    // Random frames against the reference model.
    for (int r = 0; r < 3; r++) begin
      w = rand_w();
      for (int p = 0; p < IB; p++)
        for (int k = 0; k < N/32; k++) f[p][32*k +: 32] = $urandom;
      send_frame(w, f, IB'($urandom), 1'b1, IB, model(w, f));
      collect(r);
    end

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
